// File: rtl/prio_pkg.sv
// rtl/prio_pkg.sv - shared definitions for the priority encode/decode path
// Contents:
//   DEF_IDX_W, DEF_OUT_W : default index width / one-hot width
//   ST_IDLE, ST_HOLD     : state encoding constants, wrapped by state_t
//   onehot(idx, out_w)   : one-hot vector for idx, all-zero when idx >= out_w
package prio_pkg;

  localparam int DEF_IDX_W = 3;
  localparam int DEF_OUT_W = 8;
  localparam int MAX_OUT_W = 256;

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_HOLD = 1'b1;

  typedef enum logic {
    S_IDLE = ST_IDLE,
    S_HOLD = ST_HOLD
  } state_t;

  // Returned at the widest legal size so one function serves every OUT_W;
  // callers keep the low out_w bits. An out-of-range index yields zero, so
  // the OR of the result doubles as an "index in range" flag.
  function automatic logic [MAX_OUT_W-1:0] onehot(input logic [7:0] idx,
                                                  input int out_w);
    logic [MAX_OUT_W-1:0] r;
    r = '0;
    if (int'(idx) < out_w) r[idx] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/prio_hold_counter.sv
// rtl/prio_hold_counter.sv - loadable down-counter with zero flag
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   load      : load load_val (wins over dec)
//   load_val  : value to load
//   dec       : decrement by one; holds at zero
//   zero      : count is zero
module prio_hold_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/priority_decoder_seq.sv
// rtl/priority_decoder_seq.sv - sequenced index-to-one-hot decoder with hold
// Ports:
//   clk, rst           : clock, asynchronous active-high reset
//   enable             : gates acceptance of new indices (never aborts a hold)
//   in_valid, in_ready : index handshake; in_ready is combinational
//   in_idx             : encoded index, bit 0 = index 0
//   y, y_valid         : registered one-hot select held HOLD cycles; y_valid = |y
//   err                : one-cycle pulse for an accepted index >= OUT_W
//   evt_cnt            : wrapping count of successfully decoded indices
module priority_decoder_seq
  import prio_pkg::*;
#(
  parameter int IDX_W = DEF_IDX_W,
  parameter int OUT_W = DEF_OUT_W,
  parameter int HOLD  = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IDX_W-1:0] in_idx,
  output logic [OUT_W-1:0] y,
  output logic             y_valid,
  output logic             err,
  output logic [CNT_W-1:0] evt_cnt
);

  localparam logic [7:0] HOLD_M1 = 8'(HOLD - 1);

  state_t               state, state_n;
  logic [OUT_W-1:0]     y_n;
  logic                 err_n;
  logic                 evt_inc;
  logic                 cnt_load;
  logic                 cnt_dec;
  logic                 cnt_zero;
  logic                 accept;
  logic [7:0]           idx8;
  logic [MAX_OUT_W-1:0] oh_full;
  logic                 idx_ok;
  logic [OUT_W-1:0]     oh;

  prio_hold_counter #(.W(8)) u_hold (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (HOLD_M1),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  always_comb begin
    idx8    = 8'(in_idx);
    oh_full = onehot(idx8, OUT_W);
    idx_ok  = |oh_full;
    oh      = oh_full[OUT_W-1:0];
  end

  // The counter holds HOLD-1 after a load, so reaching zero marks the last
  // held cycle; accepting then gives a gapless handover to the next select.
  assign in_ready = ~rst & enable & ((state == S_IDLE) | cnt_zero);
  assign accept   = in_valid & in_ready;
  assign y_valid  = |y;

  always_comb begin
    state_n  = state;
    y_n      = y;
    err_n    = 1'b0;
    evt_inc  = 1'b0;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (idx_ok) begin
            y_n      = oh;
            state_n  = S_HOLD;
            cnt_load = 1'b1;
            evt_inc  = 1'b1;
          end else begin
            err_n = 1'b1;
          end
        end
      end
      S_HOLD: begin
        if (!cnt_zero) begin
          cnt_dec = 1'b1;
        end else if (accept && idx_ok) begin
          y_n      = oh;
          cnt_load = 1'b1;
          evt_inc  = 1'b1;
        end else begin
          y_n     = '0;
          state_n = S_IDLE;
          err_n   = accept;
        end
      end
      default: begin
        y_n     = '0;
        state_n = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      y       <= '0;
      err     <= 1'b0;
      evt_cnt <= '0;
    end else begin
      state <= state_n;
      y     <= y_n;
      err   <= err_n;
      if (evt_inc) evt_cnt <= evt_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_priority_decoder_seq.sv
// tb/tb_priority_decoder_seq.sv - self-checking bench for priority_decoder_seq
module tb_priority_decoder_seq;

  localparam int N = 3;
  localparam int OUTW  [N] = '{8, 6, 8};
  localparam int HOLDV [N] = '{4, 4, 1};

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic enable = 1'b0;
  logic in_valid = 1'b0;
  logic [2:0] in_idx = 3'd0;

  logic [7:0] y0, y2;
  logic [5:0] y1;
  logic       rdy [N];
  logic       yv  [N];
  logic       er  [N];
  logic [7:0] ev  [N];
  logic [7:0] dy  [N];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  priority_decoder_seq #(.IDX_W(3), .OUT_W(8), .HOLD(4), .CNT_W(8)) u0 (
    .clk(clk), .rst(rst), .enable(enable), .in_valid(in_valid), .in_ready(rdy[0]),
    .in_idx(in_idx), .y(y0), .y_valid(yv[0]), .err(er[0]), .evt_cnt(ev[0]));
  priority_decoder_seq #(.IDX_W(3), .OUT_W(6), .HOLD(4), .CNT_W(8)) u1 (
    .clk(clk), .rst(rst), .enable(enable), .in_valid(in_valid), .in_ready(rdy[1]),
    .in_idx(in_idx), .y(y1), .y_valid(yv[1]), .err(er[1]), .evt_cnt(ev[1]));
  priority_decoder_seq #(.IDX_W(3), .OUT_W(8), .HOLD(1), .CNT_W(8)) u2 (
    .clk(clk), .rst(rst), .enable(enable), .in_valid(in_valid), .in_ready(rdy[2]),
    .in_idx(in_idx), .y(y2), .y_valid(yv[2]), .err(er[2]), .evt_cnt(ev[2]));

  assign dy[0] = y0;
  assign dy[1] = {2'b00, y1};
  assign dy[2] = y2;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: m_left is how many more cycles (including the current one) the
  // shown select remains on the output; a new index may enter only when the
  // current cycle is the last one shown (or nothing is shown).
  logic [7:0] m_y    [N];
  int         m_left [N];
  logic [7:0] m_evt  [N];
  logic       m_err  [N];

  function automatic logic m_ready(input int i);
    return enable && !rst && (m_left[i] <= 1);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        m_y[i] = 8'd0; m_left[i] = 0; m_evt[i] = 8'd0; m_err[i] = 1'b0;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (in_valid && m_ready(i)) begin
          if (int'(in_idx) < OUTW[i]) begin
            m_y[i] = 8'd1 << in_idx; m_left[i] = HOLDV[i];
            m_evt[i] = m_evt[i] + 8'd1; m_err[i] = 1'b0;
          end else begin
            m_y[i] = 8'd0; m_left[i] = 0; m_err[i] = 1'b1;
          end
        end else begin
          m_err[i] = 1'b0;
          if (m_left[i] > 1) m_left[i] = m_left[i] - 1;
          else begin m_y[i] = 8'd0; m_left[i] = 0; end
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      chk($sformatf("u%0d.y", i), 32'(dy[i]), 32'(m_y[i]));
      chk($sformatf("u%0d.y_valid", i), 32'(yv[i]), 32'(m_y[i] != 8'd0));
      chk($sformatf("u%0d.err", i), 32'(er[i]), 32'(m_err[i]));
      chk($sformatf("u%0d.evt_cnt", i), 32'(ev[i]), 32'(m_evt[i]));
      chk($sformatf("u%0d.in_ready", i), 32'(rdy[i]), 32'(m_ready(i)));
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    tick();
    rst = 1'b1; in_valid = 1'b0; enable = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    // reset state
    tick();
    chk("rst.y", 32'(y0), 32'h0);
    chk("rst.evt", 32'(ev[0]), 32'h0);
    chk("rst.in_ready", 32'(rdy[0]), 32'h0);
    do_reset();

    // 1: single accept of index 5
    in_valid = 1'b1; in_idx = 3'd5;
    tick(); in_valid = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      chk($sformatf("t1.y c%0d", c), 32'(y0), 32'h20);
      chk($sformatf("t1.yv c%0d", c), 32'(yv[0]), 32'h1);
      chk($sformatf("t1.rdy c%0d", c), 32'(rdy[0]), (c == 4) ? 32'h1 : 32'h0);
      tick();
    end
    chk("t1.y c5", 32'(y0), 32'h0);
    chk("t1.evt", 32'(ev[0]), 32'h1);

    // 2: back-to-back 0 then 7 with no gap
    do_reset();
    in_valid = 1'b1; in_idx = 3'd0;
    tick(); in_idx = 3'd7;
    for (int c = 1; c <= 4; c++) begin
      chk($sformatf("t2.y0 c%0d", c), 32'(y0), 32'h01);
      tick();
    end
    in_valid = 1'b0;
    for (int c = 5; c <= 8; c++) begin
      chk($sformatf("t2.y7 c%0d", c), 32'(y0), 32'h80);
      tick();
    end
    chk("t2.evt", 32'(ev[0]), 32'h2);

    // 3: out-of-range index on OUT_W=6
    do_reset();
    in_valid = 1'b1; in_idx = 3'd6;
    tick(); in_valid = 1'b0;
    chk("t3.err", 32'(er[1]), 32'h1);
    chk("t3.y", 32'(y1), 32'h0);
    chk("t3.rdy", 32'(rdy[1]), 32'h1);
    tick();
    chk("t3.err2", 32'(er[1]), 32'h0);
    chk("t3.evt", 32'(ev[1]), 32'h0);

    // 4: enable dropped mid-hold
    do_reset();
    in_valid = 1'b1; in_idx = 3'd3;
    tick(); in_idx = 3'd1;
    chk("t4.y c1", 32'(y0), 32'h08);
    tick(); enable = 1'b0;
    for (int c = 2; c <= 4; c++) begin
      chk($sformatf("t4.y c%0d", c), 32'(y0), 32'h08);
      tick();
    end
    chk("t4.y c5", 32'(y0), 32'h00);
    tick();
    chk("t4.y c6", 32'(y0), 32'h00);
    enable = 1'b1;
    tick(); in_valid = 1'b0;
    chk("t4.y idx1", 32'(y0), 32'h02);
    chk("t4.evt", 32'(ev[0]), 32'h2);

    // 5: asynchronous reset mid-hold
    do_reset();
    in_valid = 1'b1; in_idx = 3'd2;
    tick(); in_valid = 1'b0;
    chk("t5.y pre", 32'(y0), 32'h04);
    tick();
    #4 rst = 1'b1;
    #1;
    chk("t5.y async", 32'(y0), 32'h0);
    chk("t5.yv async", 32'(yv[0]), 32'h0);
    chk("t5.err async", 32'(er[0]), 32'h0);
    chk("t5.evt async", 32'(ev[0]), 32'h0);
    tick(); rst = 1'b0;
    in_valid = 1'b1; in_idx = 3'd2;
    tick(); in_valid = 1'b0;
    chk("t5.y post", 32'(y0), 32'h04);

    // 6: HOLD=1, 256 consecutive accepts, counter wraps
    do_reset();
    in_valid = 1'b1;
    for (int n = 0; n < 256; n++) begin
      in_idx = 3'(n % 8);
      tick();
      chk($sformatf("t6.y n%0d", n), 32'(y2), 32'(8'd1 << (n % 8)));
      chk($sformatf("t6.yv n%0d", n), 32'(yv[2]), 32'h1);
      chk($sformatf("t6.evt n%0d", n), 32'(ev[2]), 32'((n + 1) % 256));
    end
    in_valid = 1'b0;
    tick();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
